// File: rtl/mips4_pkg.sv
// Shared definitions for the 4-stage MIPS pipeline: defaults, opcodes,
// instruction field positions and the fetch FSM state type.
package mips4_pkg;

  localparam int unsigned INSTR_W_DEF = 8;
  localparam int unsigned PC_W_DEF    = 8;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int unsigned OPCODE_MSB = 7;
  localparam int unsigned OPCODE_LSB = 6;
  localparam int unsigned TARGET_MSB = 5;
  localparam int unsigned TARGET_LSB = 0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    JBUB = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline boundary register with hold and kill. Kill wins over hold and
// clears both valid and data so a bubble never carries a stale word.
module if_id_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              kill,
  input  logic [DATA_W-1:0] data_d,
  input  logic [TAG_W-1:0]  tag_d,
  output logic [DATA_W-1:0] data_q,
  output logic [TAG_W-1:0]  tag_q,
  output logic              valid_q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (kill) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (!hold) begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, BOOT/RUN/JBUB control and the IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips4_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter int unsigned        INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               jmp_valid_i,
  input  logic [INSTR_W-3:0] jmp_target_i,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [PC_W-1:0]    if_id_pc_o,
  output logic               if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt_o,
  output logic [15:0]        flush_cnt_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            capture;
  logic            kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    kill    = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (jmp_valid_i) begin
          pc_d    = PC_W'(jmp_target_i);
          kill    = 1'b1;
          state_d = JBUB;
        end else if (!stall_i) begin
          capture = 1'b1;
          pc_d    = pc_q + 1'b1;
        end
      end
      // ID holds the killed slot here, so any jmp_valid_i is spurious.
      JBUB: begin
        if (!stall_i) begin
          capture = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign imem_addr_o = pc_q;

  if_id_reg #(
    .DATA_W (INSTR_W),
    .TAG_W  (PC_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (!capture),
    .kill    (kill),
    .data_d  (imem_rdata_i),
    .tag_d   (pc_q),
    .data_q  (if_id_instr_o),
    .tag_q   (if_id_pc_o),
    .valid_q (if_id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (capture && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (kill && flush_cnt_q != 16'hFFFF)    flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // Counters compiled out; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected
// IF/ID contents before each edge and the values are popped after it.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       jmp_valid = 1'b0;
  logic [5:0] jmp_target = '0;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc;
  logic       if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
    logic       valid;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: 0=BOOT, 1=RUN, 2=JBUB
  int         m_state;
  logic [7:0] m_pc, m_instr, m_ifpc;
  logic       m_valid;

  always #5 clk = ~clk;

  assign imem_rdata = 8'h10 + imem_addr;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .stall_i       (stall),
    .jmp_valid_i   (jmp_valid),
    .jmp_target_i  (jmp_target),
    .if_id_instr_o (if_id_instr),
    .if_id_pc_o    (if_id_pc),
    .if_id_valid_o (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  task automatic model_reset();
    m_state = 0;
    m_pc    = 8'h00;
    m_instr = 8'h00;
    m_ifpc  = 8'h00;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_fetch();
    m_instr = 8'h10 + m_pc;
    m_ifpc  = m_pc;
    m_valid = 1'b1;
    m_pc    = m_pc + 8'h01;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_and_push();
    exp_t e;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (jmp_valid) begin
          m_pc    = {2'b00, jmp_target};
          m_valid = 1'b0;
          m_instr = 8'h00;
          m_state = 2;
        end else if (!stall) begin
          model_fetch();
        end
      end
      default: begin
        if (!stall) begin
          model_fetch();
          m_state = 1;
        end
      end
    endcase
    e.instr = m_instr;
    e.pc    = m_ifpc;
    e.valid = m_valid;
    e.addr  = m_pc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_and_push();
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: no expected entry at time %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (if_id_instr !== e.instr || if_id_pc !== e.pc ||
          if_id_valid !== e.valid || imem_addr !== e.addr) begin
        miscompares++;
        $display("FAIL sb: got instr=%h pc=%h valid=%b addr=%h, want instr=%h pc=%h valid=%b addr=%h",
                 if_id_instr, if_id_pc, if_id_valid, imem_addr,
                 e.instr, e.pc, e.valid, e.addr);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] want_pc [3];
    logic [7:0] want_in [3];
    want_pc = '{8'h00, 8'h01, 8'h02};
    want_in = '{8'h10, 8'h11, 8'h12};
    rst_n = 1'b0;
    stall = 1'b0;
    jmp_valid = 1'b0;
    #12;
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00 ||
        if_id_pc !== 8'h00 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_values: instr=%h pc=%h valid=%b addr=%h, want all zero",
               if_id_instr, if_id_pc, if_id_valid, imem_addr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if (if_id_valid !== 1'b0 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL boot_edge: valid=%b addr=%h, want valid=0 addr=00",
               if_id_valid, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (if_id_pc !== want_pc[i] || if_id_instr !== want_in[i] || if_id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL first_fetch%0d: pc=%h instr=%h valid=%b, want pc=%h instr=%h valid=1",
                 i, if_id_pc, if_id_instr, if_id_valid, want_pc[i], want_in[i]);
      end
    end
  endtask

  task automatic test_stall();
    repeat (3) step();
    stall = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (if_id_pc !== 8'h05 || if_id_instr !== 8'h15 ||
          if_id_valid !== 1'b1 || imem_addr !== 8'h06) begin
        miscompares++;
        $display("FAIL stall_hold: pc=%h instr=%h valid=%b addr=%h, want pc=05 instr=15 valid=1 addr=06",
                 if_id_pc, if_id_instr, if_id_valid, imem_addr);
      end
    end
    stall = 1'b0;
    step();
    vectors++;
    if (if_id_pc !== 8'h06 || if_id_instr !== 8'h16) begin
      miscompares++;
      $display("FAIL stall_resume: pc=%h instr=%h, want pc=06 instr=16", if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_jump();
    step();
    jmp_valid = 1'b1;
    jmp_target = 6'h20;
    vectors++;
    if (imem_addr !== 8'h08) begin
      miscompares++;
      $display("FAIL jump_setup: addr=%h, want 08", imem_addr);
    end
    step();
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00 || imem_addr !== 8'h20) begin
      miscompares++;
      $display("FAIL jump_bubble: valid=%b instr=%h addr=%h, want valid=0 instr=00 addr=20",
               if_id_valid, if_id_instr, imem_addr);
    end
    jmp_target = 6'h05;
    step();
    jmp_valid = 1'b0;
    vectors++;
    if (if_id_pc !== 8'h20 || if_id_instr !== 8'h30 ||
        if_id_valid !== 1'b1 || imem_addr !== 8'h21) begin
      miscompares++;
      $display("FAIL jump_target: pc=%h instr=%h valid=%b addr=%h, want pc=20 instr=30 valid=1 addr=21",
               if_id_pc, if_id_instr, if_id_valid, imem_addr);
    end
  endtask

  task automatic test_jump_stall();
    jmp_valid = 1'b1;
    stall = 1'b1;
    jmp_target = 6'h3F;
    step();
    jmp_valid = 1'b0;
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00 || imem_addr !== 8'h3F) begin
      miscompares++;
      $display("FAIL jump_over_stall: valid=%b instr=%h addr=%h, want valid=0 instr=00 addr=3f",
               if_id_valid, if_id_instr, imem_addr);
    end
    step();
    vectors++;
    if (if_id_valid !== 1'b0 || imem_addr !== 8'h3F) begin
      miscompares++;
      $display("FAIL jbub_stall: valid=%b addr=%h, want valid=0 addr=3f", if_id_valid, imem_addr);
    end
    stall = 1'b0;
    step();
    vectors++;
    if (if_id_pc !== 8'h3F || if_id_instr !== 8'h4F ||
        if_id_valid !== 1'b1 || imem_addr !== 8'h40) begin
      miscompares++;
      $display("FAIL jbub_release: pc=%h instr=%h valid=%b addr=%h, want pc=3f instr=4f valid=1 addr=40",
               if_id_pc, if_id_instr, if_id_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    while (if_id_pc !== 8'hFF && n < 300) begin
      step();
      n++;
    end
    vectors++;
    if (if_id_pc !== 8'hFF || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_reach: pc=%h addr=%h after %0d cycles, want pc=ff addr=00",
               if_id_pc, imem_addr, n);
    end
    step();
    vectors++;
    if (if_id_pc !== 8'h00 || if_id_instr !== 8'h10 ||
        if_id_valid !== 1'b1 || imem_addr !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap: pc=%h instr=%h valid=%b addr=%h, want pc=00 instr=10 valid=1 addr=01",
               if_id_pc, if_id_instr, if_id_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00 ||
        if_id_pc !== 8'h00 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: instr=%h pc=%h valid=%b addr=%h, want all zero",
               if_id_instr, if_id_pc, if_id_valid, imem_addr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if (if_id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reboot_edge1: valid=%b, want 0", if_id_valid);
    end
    step();
    vectors++;
    if (if_id_pc !== 8'h00 || if_id_instr !== 8'h10 || if_id_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reboot_edge2: pc=%h instr=%h valid=%b, want pc=00 instr=10 valid=1",
               if_id_pc, if_id_instr, if_id_valid);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    repeat (8) step();
    jmp_valid = 1'b1;
    jmp_target = 6'h10;
    step();
    jmp_valid = 1'b0;
    step();
    jmp_valid = 1'b1;
    jmp_target = 6'h20;
    step();
    jmp_valid = 1'b0;
    step();
    vectors++;
    if (fetch_cnt !== 16'd10 || flush_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL perf_counts: fetch=%0d flush=%0d, want fetch=10 flush=2", fetch_cnt, flush_cnt);
    end
    force dut.fetch_cnt_q = 16'hFFFF;
    #2;
    release dut.fetch_cnt_q;
    step();
    vectors++;
    if (fetch_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL perf_saturate: fetch=%h, want ffff", fetch_cnt);
    end
  endtask
`else
  task automatic test_perf_cnt();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_stall();
    test_jump();
    test_jump_stall();
    test_wrap();
    test_reset_mid();
    test_perf_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 4-stage MIPS pipeline.
- Drives the instruction-memory address, captures the returned instruction and its PC, and presents them to decode. Decode slices opcode [7:6] into the control unit.
- Takes redirects from decode's qualified jump signal.
- Takes stalls from the hazard logic.

Parameters:
- PC_W, 8, program counter width; must satisfy PC_W >= INSTR_W-2.
- INSTR_W, 8, instruction width; opcode is the top 2 bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr_o  out  PC_W  instruction-memory address; combinational copy of pc_q.
- imem_rdata_i  in  INSTR_W  instruction word; combinational-read memory, valid in the same cycle.
- stall_i  in  1  hold PC and IF/ID contents.
- jmp_valid_i  in  1  decode's Pc_jmp_select, ANDed with the ID valid bit.
- jmp_target_i  in  INSTR_W-2  absolute jump target (instr[5:0] of the jump).
- if_id_instr_o  out  INSTR_W  registered instruction to decode.
- if_id_pc_o  out  PC_W  registered PC of that instruction.
- if_id_valid_o  out  1  registered valid; decode gates Reg_write and Out_control with it.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - pc_q=RESET_PC, imem_addr_o=RESET_PC.
  - if_id_instr_o=0, if_id_pc_o=0, if_id_valid_o=0.
  - state=BOOT.
- FSM states: BOOT, RUN, JBUB.
- BOOT:
  - Lasts exactly one cycle after reset release; no capture, PC held.
  - stall_i and jmp_valid_i are ignored.
  - Next state is RUN.
- RUN, evaluated every rising edge in priority order:
  1. jmp_valid_i=1:
     - pc_q <= zero-extended jmp_target_i.
     - if_id_valid_o <= 0, if_id_instr_o <= 0 (kills the wrong-path fetch).
     - Next state JBUB.
     - A jump overrides a simultaneous stall_i.
  2. stall_i=1: pc_q and all IF/ID outputs hold; stay in RUN.
  3. Otherwise:
     - if_id_instr_o <= imem_rdata_i, if_id_pc_o <= pc_q, if_id_valid_o <= 1.
     - pc_q <= pc_q+1 modulo 2^PC_W (wraps from all-ones to 0, no flag).
- JBUB:
  - ID holds a bubble in this state, so jmp_valid_i is ignored as spurious.
  - stall_i=1: hold, stay in JBUB.
  - Otherwise perform the normal fetch of the target and go to RUN.
- Latency: an instruction at address A appears on if_id_* one cycle after pc_q=A.
- Jump penalty is exactly one bubble.
- Invalid IF/ID always carries instr=0. The valid bit is authoritative; opcode 00 decodes to a write, so the bubble must be gated by valid.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). The first capture is 2 edges after release.
- Jump target zero-extension: upper PC_W-(INSTR_W-2) bits are 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt_o[15:0], counting normal captures.
  - Adds outputs flush_cnt_o[15:0], counting accepted jumps.
  - Both reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package mips4_pkg:
  - Opcode constants OP_ALU=2'b00, OP_LD=2'b01, OP_JMP=2'b11.
  - Default INSTR_W and PC_W.
  - Fetch FSM state enum {BOOT, RUN, JBUB}.
  - Field slice constants (opcode [7:6], target [5:0]).
- One sub-module, if_id_reg: IF/ID register with hold (stall) and kill (flush) inputs, reused for the ID/EX boundary later.
- PC and FSM stay in fetch_stage.

Test Plan:
- Reset then free run with imem[i]=8'h10+i:
  - Edge 1 after release: still BOOT, valid=0.
  - Edges 2,3,4: if_id_pc=0,1,2 and instr=10,11,12, valid=1.
- stall_i high 3 cycles while if_id_pc=5: outputs frozen at pc=5; pc_q stays 6; resumes with pc=6.
- jmp_valid_i=1 with target 6'h20 while pc_q=8:
  - Next edge: valid=0, instr=0.
  - Following edge: if_id_pc=8'h20, valid=1.
  - A jmp_valid_i pulse during the JBUB cycle is ignored.
- jmp_valid_i and stall_i both high: jump taken (pc_q=target, bubble inserted).
- PC_W=8 run through 8'hFF: next captured pc=8'h00, no stall or glitch. rst_n dropped mid-run: outputs zero immediately, without waiting for a clock edge.
- FETCH_PERF_CNT_EN build: 10 fetches and 2 jumps give fetch_cnt=10, flush_cnt=2. Forced counter value 16'hFFFF stays at FFFF.
